// File: rtl/tracker_axis_scheduler_if.sv
// Bus bundle between the tracker scheduler (master) and the LDR ADC plus the two servo drivers (slave).
interface tracker_axis_scheduler_if #(
   parameter int ADC_W = 12
);
   // ADC handshake: adc_req is a one-cycle pulse qualified by adc_ch; the ADC answers later with a
   // one-cycle adc_valid carrying adc_data. No back-pressure, and no new req is issued before the valid.
   logic             adc_req;
   logic [1:0]       adc_ch;
   logic             adc_valid;
   logic [ADC_W-1:0] adc_data;
   logic [31:0]      pos_h;
   logic [31:0]      pos_v;
   logic             h_btn0;
   logic             h_btn1;
   logic             v_btn0;
   logic             v_btn1;

   modport master (
      output adc_req, adc_ch, h_btn0, h_btn1, v_btn0, v_btn1,
      input  adc_valid, adc_data, pos_h, pos_v
   );

   modport slave (
      input  adc_req, adc_ch, h_btn0, h_btn1, v_btn0, v_btn1,
      output adc_valid, adc_data, pos_h, pos_v
   );
endinterface

// File: rtl/tracker_axis_scheduler.sv
// Two-axis solar tracker sequencer: LDR sampling, error evaluation, one-axis-at-a-time servo moves.
// Optional ADC watchdog (WAIT timeout into a FAULT state) enabled by defining TRACKER_ADC_WDOG_EN.
module tracker_axis_scheduler #(
   parameter int ADC_W          = 12,
   parameter int DEADBAND       = 64,
   parameter int MOVE_CYCLES    = 200000,
   parameter int SETTLE_CYCLES  = 100000,
   parameter int RECHECK_CYCLES = 1000000,
   parameter int POS_MIN        = 500,
   parameter int POS_MAX        = 2500,
   parameter int ADC_TIMEOUT    = 4096
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            EN,
   tracker_axis_scheduler_if.master        bus,
   output logic                            busy,
   output logic                            locked,
   output logic                            fault,
   output logic [2:0]                      state_dbg
);
   localparam int MAX_MS  = (MOVE_CYCLES > SETTLE_CYCLES) ? MOVE_CYCLES : SETTLE_CYCLES;
   localparam int MAX_MSR = (MAX_MS > RECHECK_CYCLES) ? MAX_MS : RECHECK_CYCLES;
   localparam int MAX_ALL = (MAX_MSR > ADC_TIMEOUT) ? MAX_MSR : ADC_TIMEOUT;
   localparam int CW      = $clog2(MAX_ALL) + 1;
   localparam int EW      = ADC_W + 3;
   localparam logic signed [EW-1:0] DB = EW'(DEADBAND);
   localparam logic AXIS_H = 1'b0;
   localparam logic AXIS_V = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      WAIT   = 3'd2,
      EVAL   = 3'd3,
      MOVE   = 3'd4,
      SETTLE = 3'd5,
      LOCKED = 3'd6
`ifdef TRACKER_ADC_WDOG_EN
      , FAULT = 3'd7
`endif
   } state_t;

   state_t                    state_q, state_d;
   logic [1:0]                ch_q, ch_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [3:0][ADC_W-1:0]     samp_q, samp_d;
   logic                      last_axis_q, last_axis_d;
   logic                      mv_axis_q, mv_axis_d;
   logic                      mv_dir_q, mv_dir_d;
   logic                      adc_req_q, adc_req_d;
   logic                      h_btn0_q, h_btn0_d, h_btn1_q, h_btn1_d;
   logic                      v_btn0_q, v_btn0_d, v_btn1_q, v_btn1_d;
   logic                      busy_q, busy_d;
   logic                      locked_q, locked_d;
`ifdef TRACKER_ADC_WDOG_EN
   logic                      fault_q, fault_d;
`endif

   // Channel order is TL, TR, BL, BR; sums are widened so the subtraction cannot wrap.
   logic [ADC_W:0]            sum_l, sum_r, sum_t, sum_b;
   logic signed [EW-1:0]      eh, ev;
   logic                      need_h, need_v, grant_v;
   logic [31:0]               pos_sel;
   logic                      limit_hit;

   assign sum_l = {1'b0, samp_q[0]} + {1'b0, samp_q[2]};
   assign sum_r = {1'b0, samp_q[1]} + {1'b0, samp_q[3]};
   assign sum_t = {1'b0, samp_q[0]} + {1'b0, samp_q[1]};
   assign sum_b = {1'b0, samp_q[2]} + {1'b0, samp_q[3]};
   assign eh    = $signed({2'b00, sum_l}) - $signed({2'b00, sum_r});
   assign ev    = $signed({2'b00, sum_t}) - $signed({2'b00, sum_b});

   assign need_h = ((eh > DB) && (bus.pos_h < 32'(POS_MAX))) ||
                   ((eh < -DB) && (bus.pos_h > 32'(POS_MIN)));
   assign need_v = ((ev > DB) && (bus.pos_v < 32'(POS_MAX))) ||
                   ((ev < -DB) && (bus.pos_v > 32'(POS_MIN)));
   // When both axes want to move, the one that did not move last gets the grant.
   assign grant_v = need_v && (!need_h || (last_axis_q == AXIS_H));

   assign pos_sel   = (mv_axis_q == AXIS_V) ? bus.pos_v : bus.pos_h;
   assign limit_hit = mv_dir_q ? (pos_sel <= 32'(POS_MIN)) : (pos_sel >= 32'(POS_MAX));

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      cnt_d       = cnt_q;
      samp_d      = samp_q;
      last_axis_d = last_axis_q;
      mv_axis_d   = mv_axis_q;
      mv_dir_d    = mv_dir_q;
      adc_req_d   = 1'b0;
      h_btn0_d    = 1'b0;
      h_btn1_d    = 1'b0;
      v_btn0_d    = 1'b0;
      v_btn1_d    = 1'b0;
      busy_d      = busy_q;
      locked_d    = locked_q;
`ifdef TRACKER_ADC_WDOG_EN
      fault_d     = fault_q;
`endif
      if (!EN) begin
         state_d  = IDLE;
         ch_d     = 2'd0;
         cnt_d    = '0;
         busy_d   = 1'b0;
         locked_d = 1'b0;
`ifdef TRACKER_ADC_WDOG_EN
         fault_d  = 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_d = REQ;
               ch_d    = 2'd0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
            REQ: begin
               adc_req_d = 1'b1;
               state_d   = WAIT;
               cnt_d     = '0;
            end
            WAIT: begin
               if (bus.adc_valid) begin
                  samp_d[ch_q] = bus.adc_data;
                  cnt_d        = '0;
                  if (ch_q == 2'd3) begin
                     state_d = EVAL;
                  end else begin
                     ch_d    = ch_q + 2'd1;
                     state_d = REQ;
                  end
               end
`ifdef TRACKER_ADC_WDOG_EN
               else if (cnt_q == CW'(ADC_TIMEOUT - 1)) begin
                  state_d = FAULT;
                  cnt_d   = '0;
                  fault_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end
            EVAL: begin
               cnt_d = '0;
               if (!need_h && !need_v) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                  busy_d   = 1'b0;
               end else begin
                  state_d     = MOVE;
                  mv_axis_d   = grant_v ? AXIS_V : AXIS_H;
                  last_axis_d = grant_v ? AXIS_V : AXIS_H;
                  mv_dir_d    = grant_v ? (ev < 0) : (eh < 0);
               end
            end
            MOVE: begin
               if (limit_hit || (cnt_q == CW'(MOVE_CYCLES))) begin
                  state_d = SETTLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d    = cnt_q + 1'b1;
                  h_btn0_d = (mv_axis_q == AXIS_H) && !mv_dir_q;
                  h_btn1_d = (mv_axis_q == AXIS_H) && mv_dir_q;
                  v_btn0_d = (mv_axis_q == AXIS_V) && !mv_dir_q;
                  v_btn1_d = (mv_axis_q == AXIS_V) && mv_dir_q;
               end
            end
            SETTLE: begin
               if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                  state_d = REQ;
                  ch_d    = 2'd0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            LOCKED: begin
               if (cnt_q == CW'(RECHECK_CYCLES - 1)) begin
                  state_d  = REQ;
                  ch_d     = 2'd0;
                  cnt_d    = '0;
                  locked_d = 1'b0;
                  busy_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         ch_q        <= 2'd0;
         cnt_q       <= '0;
         samp_q      <= '0;
         last_axis_q <= AXIS_V;
         mv_axis_q   <= AXIS_H;
         mv_dir_q    <= 1'b0;
         adc_req_q   <= 1'b0;
         h_btn0_q    <= 1'b0;
         h_btn1_q    <= 1'b0;
         v_btn0_q    <= 1'b0;
         v_btn1_q    <= 1'b0;
         busy_q      <= 1'b0;
         locked_q    <= 1'b0;
`ifdef TRACKER_ADC_WDOG_EN
         fault_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         cnt_q       <= cnt_d;
         samp_q      <= samp_d;
         last_axis_q <= last_axis_d;
         mv_axis_q   <= mv_axis_d;
         mv_dir_q    <= mv_dir_d;
         adc_req_q   <= adc_req_d;
         h_btn0_q    <= h_btn0_d;
         h_btn1_q    <= h_btn1_d;
         v_btn0_q    <= v_btn0_d;
         v_btn1_q    <= v_btn1_d;
         busy_q      <= busy_d;
         locked_q    <= locked_d;
`ifdef TRACKER_ADC_WDOG_EN
         fault_q     <= fault_d;
`endif
      end
   end

   assign bus.adc_req = adc_req_q;
   assign bus.adc_ch  = ch_q;
   assign bus.h_btn0  = h_btn0_q;
   assign bus.h_btn1  = h_btn1_q;
   assign bus.v_btn0  = v_btn0_q;
   assign bus.v_btn1  = v_btn1_q;
   assign busy        = busy_q;
   assign locked      = locked_q;
   assign state_dbg   = state_q;
`ifdef TRACKER_ADC_WDOG_EN
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_tracker_axis_scheduler.sv
// Self-checking bench for tracker_axis_scheduler: vector table plus multi-cycle corner sequences.
module tb_tracker_axis_scheduler;
   localparam int ADC_W    = 12;
   localparam int DBAND    = 64;
   localparam int MOVE_C   = 20;
   localparam int SETTLE_C = 10;
   localparam int RECHK_C  = 30;
   localparam int PMIN     = 500;
   localparam int PMAX     = 2500;
   localparam int TMO      = 50;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_REQ    = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd5;

   logic clk = 1'b0;
   logic rst, en;
   logic busy, locked, fault;
   logic [2:0] state_dbg;
   logic [3:0] btns;

   tracker_axis_scheduler_if #(.ADC_W(ADC_W)) bus();

   tracker_axis_scheduler #(
      .ADC_W(ADC_W), .DEADBAND(DBAND), .MOVE_CYCLES(MOVE_C), .SETTLE_CYCLES(SETTLE_C),
      .RECHECK_CYCLES(RECHK_C), .POS_MIN(PMIN), .POS_MAX(PMAX), .ADC_TIMEOUT(TMO)
   ) dut (
      .CLK(clk), .RST(rst), .EN(en), .bus(bus),
      .busy(busy), .locked(locked), .fault(fault), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   assign btns = {bus.h_btn0, bus.h_btn1, bus.v_btn0, bus.v_btn1};

   int n_pass  = 0;
   int n_total = 0;

   logic [3:0]       exp_q[$];
   logic [1:0]       exp_ch_q[$];
   logic [ADC_W-1:0] samp [4];
   logic             adc_auto, auto_valid, man_valid;
   logic [ADC_W-1:0] auto_data, man_data;
   int               pend_cnt;
   logic [1:0]       pend_ch;

   assign bus.adc_valid = adc_auto ? auto_valid : man_valid;
   assign bus.adc_data  = adc_auto ? auto_data : man_data;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // ADC model: answers each request two cycles later from samp[]; checks queued channel order.
   initial begin : adc_model
      auto_valid = 1'b0;
      auto_data  = '0;
      pend_cnt   = 0;
      pend_ch    = 2'd0;
      forever begin
         @(negedge clk);
         auto_valid = 1'b0;
         if (!adc_auto) begin
            pend_cnt = 0;
         end else begin
            if (pend_cnt > 0) begin
               pend_cnt--;
               if (pend_cnt == 0) begin
                  auto_valid = 1'b1;
                  auto_data  = samp[pend_ch];
               end
            end
            if (bus.adc_req) begin
               if (exp_ch_q.size() > 0) check("round_ch", int'(bus.adc_ch), int'(exp_ch_q.pop_front()));
               pend_ch  = bus.adc_ch;
               pend_cnt = 2;
            end
         end
      end
   end

   // Move monitor: every btn rising edge is compared with the next expected grant pattern.
   initial begin : move_mon
      logic [3:0] prev;
      prev = 4'b0;
      forever begin
         @(negedge clk);
         if (btns != 4'b0 && prev == 4'b0) begin
            if (exp_q.size() > 0) check("move_grant", int'(btns), int'(exp_q.pop_front()));
            else check("unexpected_move", int'(btns), 0);
         end
         prev = btns;
      end
   end

   task automatic do_reset();
      adc_auto  = 1'b0;
      man_valid = 1'b0;
      man_data  = '0;
      en        = 1'b0;
      rst       = 1'b1;
      exp_q.delete();
      exp_ch_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_in(input int tl, input int tr, input int bl, input int br, input int ph, input int pv);
      samp[0]   = ADC_W'(tl);
      samp[1]   = ADC_W'(tr);
      samp[2]   = ADC_W'(bl);
      samp[3]   = ADC_W'(br);
      bus.pos_h = 32'(ph);
      bus.pos_v = 32'(pv);
   endtask

   task automatic wait_req(input int bound, output int cyc);
      cyc = 0;
      while (!bus.adc_req && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic wait_btn(input int bound, output int cyc);
      cyc = 0;
      while (btns == 4'b0 && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic serve(input logic [1:0] ch, input int d);
      int c;
      wait_req(100, c);
      check("serve_req_seen", int'(bus.adc_req), 1);
      check("serve_req_ch", int'(bus.adc_ch), int'(ch));
      @(negedge clk);
      man_valid = 1'b1;
      man_data  = ADC_W'(d);
      @(negedge clk);
      man_valid = 1'b0;
   endtask

   typedef struct {
      int         tl, tr, bl, br, ph, pv;
      logic [4:0] exp;  // {locked, h_btn0, h_btn1, v_btn0, v_btn1}
   } vec_t;
   vec_t vecs[13];

   initial begin : main
      int c;
      vecs[0]  = '{3000, 1000, 3000, 1000, 1500, 1500, 5'b0_1000};
      vecs[1]  = '{1000, 3000, 1000, 3000, 1500, 1500, 5'b0_0100};
      vecs[2]  = '{3000, 3000, 1000, 1000, 1500, 1500, 5'b0_0010};
      vecs[3]  = '{1000, 1000, 3000, 3000, 1500, 1500, 5'b0_0001};
      vecs[4]  = '{2000, 2000, 2000, 2000, 1500, 1500, 5'b1_0000};
      vecs[5]  = '{3000, 1000, 3000, 1000, 2500, 1500, 5'b1_0000};
      vecs[6]  = '{1000, 3000, 1000, 3000,  500, 1500, 5'b1_0000};
      vecs[7]  = '{3000, 1000, 1000, 1000, 2500, 1500, 5'b0_0010};
      vecs[8]  = '{1064, 1000, 1000, 1000, 1500, 1500, 5'b1_0000};
      vecs[9]  = '{1065, 1000, 1000, 1000, 1500, 1500, 5'b0_1000};
      vecs[10] = '{1000, 1065, 1000, 1000, 1500, 1500, 5'b0_0100};
      vecs[11] = '{3000, 3000, 1000, 1000, 1500, 2499, 5'b0_0010};
      vecs[12] = '{4095,    0, 4095,    0, 1500, 1500, 5'b0_1000};

      set_in(0, 0, 0, 0, 1500, 1500);
      do_reset();
      check("reset_outputs", int'({bus.adc_req, bus.adc_ch, btns, busy, locked, fault}), 0);
      check("reset_state", int'(state_dbg), int'(S_IDLE));

      // Manual round: EN latency, btn latency, exact move and settle lengths.
      exp_q.push_back(4'b1000);
      en = 1'b1;
      wait_req(20, c);
      check("en_to_req_latency", c, 2);
      serve(2'd0, 3000);
      serve(2'd1, 1000);
      serve(2'd2, 3000);
      serve(2'd3, 1000);
      wait_btn(20, c);
      check("valid_to_btn_latency", c, 2);
      check("busy_in_move", int'(busy), 1);
      c = 0;
      while (btns == 4'b1000 && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("move_length", c, MOVE_C);
      check("btns_after_move", int'(btns), 0);
      wait_req(100, c);
      check("settle_to_req", c, SETTLE_C + 1);
      check("req_ch_after_settle", int'(bus.adc_ch), 0);

      // Table of single-round outcomes.
      for (int i = 0; i < 13; i++) begin
         do_reset();
         set_in(vecs[i].tl, vecs[i].tr, vecs[i].bl, vecs[i].br, vecs[i].ph, vecs[i].pv);
         if (vecs[i].exp[3:0] != 4'b0) exp_q.push_back(vecs[i].exp[3:0]);
         adc_auto = 1'b1;
         en       = 1'b1;
         c = 0;
         while (!locked && btns == 4'b0 && c < 300) begin
            @(negedge clk);
            c++;
         end
         check($sformatf("vec%0d", i), int'({locked, btns}), int'(vecs[i].exp));
      end

      // Locked: duration, busy low, then a fresh 0..3 round.
      do_reset();
      set_in(2000, 2000, 2000, 2000, 1500, 1500);
      for (int r = 0; r < 2; r++)
         for (int ch = 0; ch < 4; ch++) exp_ch_q.push_back(2'(ch));
      adc_auto = 1'b1;
      en       = 1'b1;
      c = 0;
      while (!locked && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("locked_reached", int'(locked), 1);
      check("busy_in_locked", int'(busy), 0);
      c = 0;
      while (locked && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("locked_length", c, RECHK_C);
      c = 0;
      while (!locked && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("relocked", int'(locked), 1);
      check("round_ch_drained", exp_ch_q.size(), 0);

      // Round-robin over three rounds with both axes out of deadband.
      do_reset();
      set_in(3000, 1000, 1000, 1000, 1500, 1500);
      exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b1000);
      adc_auto = 1'b1;
      en       = 1'b1;
      c = 0;
      while (exp_q.size() > 0 && c < 600) begin
         @(negedge clk);
         c++;
      end
      check("rr_grants_done", exp_q.size(), 0);

      // Limit reached mid-move drops the button on the next cycle.
      do_reset();
      set_in(3000, 1000, 3000, 1000, 1500, 1500);
      exp_q.push_back(4'b1000);
      adc_auto = 1'b1;
      en       = 1'b1;
      wait_btn(200, c);
      repeat (5) @(negedge clk);
      check("pre_limit_btn", int'(btns), 4'b1000);
      bus.pos_h = 32'd2500;
      @(negedge clk);
      check("limit_btn_drop", int'(btns), 0);
      check("limit_state_settle", int'(state_dbg), int'(S_SETTLE));

      // EN drop during a move.
      do_reset();
      set_in(3000, 1000, 3000, 1000, 1500, 1500);
      exp_q.push_back(4'b1000);
      adc_auto = 1'b1;
      en       = 1'b1;
      wait_btn(200, c);
      repeat (3) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("en_drop_outputs", int'({bus.adc_req, btns, busy, locked}), 0);
      check("en_drop_state", int'(state_dbg), int'(S_IDLE));

      // Reset mid-WAIT, then a stale adc_valid that must not advance the round.
      do_reset();
      en = 1'b1;
      wait_req(20, c);
      @(negedge clk);
      check("in_wait", int'(state_dbg), int'(S_WAIT));
      rst = 1'b1;
      @(negedge clk);
      check("rst_outputs", int'({bus.adc_req, bus.adc_ch, btns, busy, locked, fault}), 0);
      check("rst_state", int'(state_dbg), int'(S_IDLE));
      rst       = 1'b0;
      man_valid = 1'b1;
      man_data  = 12'hfff;
      @(negedge clk);
      man_valid = 1'b0;
      check("stale_valid_state", int'(state_dbg), int'(S_REQ));
      @(negedge clk);
      check("restart_req_ch", int'({bus.adc_req, bus.adc_ch}), 3'b100);

`ifdef TRACKER_ADC_WDOG_EN
      do_reset();
      en = 1'b1;
      wait_req(20, c);
      c = 0;
      while (!fault && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("wdog_latency", c, TMO);
      check("wdog_outputs", int'({btns, busy}), 0);
      en = 1'b0;
      @(negedge clk);
      check("wdog_clear", int'(fault), 0);
`else
      do_reset();
      en = 1'b1;
      wait_req(20, c);
      repeat (100) @(negedge clk);
      check("no_wdog_fault", int'(fault), 0);
      check("no_wdog_still_wait", int'(state_dbg), int'(S_WAIT));
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
